// File: rtl/power_mode_manager.sv
// Autonomous power-mode sequencer: steps NORMAL -> LOW -> SLEEP -> DEEP on idle
// intervals and returns to NORMAL through a timed WAKE settle phase.
module power_mode_manager #(
  parameter int CNT_W       = 16,
  parameter int LOW_IDLE    = 256,
  parameter int SLEEP_IDLE  = 4096,
  parameter int DEEP_IDLE   = 16384,
  parameter int WAKE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       temp_active,
  input  logic       hum_active,
  input  logic       motion_active,
  input  logic       tx_active,
  input  logic       wake_evt,
  input  logic [1:0] cfg_max_depth,
  input  logic       cfg_force_en,
  input  logic [1:0] cfg_force_mode,
  output logic [1:0] power_mode,
  output logic       mode_change,
  output logic       wake_irq,
  output logic       wake_busy
);

  typedef enum logic [2:0] {
    S_NORMAL,
    S_LOW,
    S_SLEEP,
    S_DEEP,
    S_WAKE
  } state_t;

  localparam logic [CNT_W-1:0] LOW_LAST   = CNT_W'(LOW_IDLE - 1);
  localparam logic [CNT_W-1:0] SLEEP_LAST = CNT_W'(SLEEP_IDLE - 1);
  localparam logic [CNT_W-1:0] DEEP_LAST  = CNT_W'(DEEP_IDLE - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(WAKE_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] idle_cnt, idle_cnt_n;
  logic [CNT_W-1:0] wake_cnt, wake_cnt_n;
  logic [1:0]       mode_n;
  logic             any_act;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic state_t mode_to_state(input logic [1:0] m);
    state_t s;
    case (m)
      2'd0:    s = S_NORMAL;
      2'd1:    s = S_LOW;
      2'd2:    s = S_SLEEP;
      default: s = S_DEEP;
    endcase
    return s;
  endfunction

  // WAKE presents as NORMAL on the output
  function automatic logic [1:0] state_to_mode(input state_t s);
    logic [1:0] m;
    case (s)
      S_LOW:   m = 2'd1;
      S_SLEEP: m = 2'd2;
      S_DEEP:  m = 2'd3;
      default: m = 2'd0;
    endcase
    return m;
  endfunction

  assign any_act = temp_active | hum_active | motion_active | tx_active;

  always_comb begin
    state_n = state;
    if (cfg_force_en) begin
      state_n = mode_to_state(cfg_force_mode);
    end else begin
      // Branch order encodes priority: depth cap, then exits, then idle step.
      case (state)
        S_NORMAL: begin
          if (!any_act && idle_cnt == LOW_LAST && cfg_max_depth > 2'd0)
            state_n = S_LOW;
        end
        S_LOW: begin
          if (cfg_max_depth < 2'd1 || any_act || wake_evt)
            state_n = S_NORMAL;
          else if (idle_cnt == SLEEP_LAST && cfg_max_depth > 2'd1)
            state_n = S_SLEEP;
        end
        S_SLEEP: begin
          if (cfg_max_depth < 2'd2 || any_act || wake_evt)
            state_n = S_WAKE;
          else if (idle_cnt == DEEP_LAST && cfg_max_depth > 2'd2)
            state_n = S_DEEP;
        end
        S_DEEP: begin
          // temp/hum sensors are clock-gated in DEEP, so they cannot wake it
          if (cfg_max_depth < 2'd3 || wake_evt || motion_active || tx_active)
            state_n = S_WAKE;
        end
        S_WAKE: begin
          if (wake_cnt == WAKE_LAST)
            state_n = S_NORMAL;
        end
        default: state_n = S_NORMAL;
      endcase
    end

    if (cfg_force_en || any_act || state_n != state)
      idle_cnt_n = '0;
    else
      idle_cnt_n = sat_inc(idle_cnt);

    if (cfg_force_en || state != S_WAKE)
      wake_cnt_n = '0;
    else
      wake_cnt_n = sat_inc(wake_cnt);

    mode_n = state_to_mode(state_n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_NORMAL;
      idle_cnt    <= '0;
      wake_cnt    <= '0;
      power_mode  <= 2'd0;
      mode_change <= 1'b0;
      wake_irq    <= 1'b0;
      wake_busy   <= 1'b0;
    end else begin
      state       <= state_n;
      idle_cnt    <= idle_cnt_n;
      wake_cnt    <= wake_cnt_n;
      power_mode  <= mode_n;
      mode_change <= (mode_n != power_mode);
      wake_irq    <= (state_n == S_WAKE) && (state != S_WAKE);
      wake_busy   <= (state_n == S_WAKE);
    end
  end

endmodule

// File: tb/tb_power_mode_manager.sv
// Bench for power_mode_manager: directed scenarios then randomized traffic,
// all checked against a behavioural model of depth, wake countdown and idle run.
module tb_power_mode_manager;

  localparam int CNT_W    = 16;
  localparam int WAKE_CYC = 3;
  localparam int IDLE_MAX = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       temp_active, hum_active, motion_active, tx_active, wake_evt;
  logic [1:0] cfg_max_depth;
  logic       cfg_force_en;
  logic [1:0] cfg_force_mode;
  logic [1:0] power_mode;
  logic       mode_change, wake_irq, wake_busy;

  int checks = 0;
  int passes = 0;

  // model state: depth 0..3, cycles left in WAKE (0 = not waking), idle run length
  int         m_depth, m_wake_left, m_idle;
  logic [1:0] e_mode;
  logic       e_mc, e_irq, e_busy;

  power_mode_manager #(
    .CNT_W(CNT_W), .LOW_IDLE(4), .SLEEP_IDLE(8), .DEEP_IDLE(16), .WAKE_CYCLES(WAKE_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .temp_active(temp_active), .hum_active(hum_active),
    .motion_active(motion_active), .tx_active(tx_active),
    .wake_evt(wake_evt), .cfg_max_depth(cfg_max_depth),
    .cfg_force_en(cfg_force_en), .cfg_force_mode(cfg_force_mode),
    .power_mode(power_mode), .mode_change(mode_change),
    .wake_irq(wake_irq), .wake_busy(wake_busy)
  );

  always #5 clk = ~clk;

  function automatic int thr(input int d);
    return (d == 0) ? 4 : (d == 1) ? 8 : 16;
  endfunction

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checks = checks + 1;
    assert (got === exp) passes = passes + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    m_depth = 0; m_wake_left = 0; m_idle = 0;
    e_mode = 2'd0; e_mc = 1'b0; e_irq = 1'b0; e_busy = 1'b0;
  endtask

  task automatic model_step();
    int  prev, act, maxd, nd;
    bit  go_wake, entered;
    prev    = (m_wake_left > 0) ? 0 : m_depth;
    act     = int'(temp_active | hum_active | motion_active | tx_active);
    maxd    = int'(cfg_max_depth);
    go_wake = 0;
    entered = 0;
    if (cfg_force_en) begin
      m_depth = int'(cfg_force_mode); m_wake_left = 0; m_idle = 0;
    end else if (m_wake_left > 0) begin
      m_wake_left = m_wake_left - 1;
      m_idle = 0;
      if (m_wake_left == 0) m_depth = 0;
    end else begin
      nd = m_depth;
      if (m_depth == 1 && (maxd < 1 || act != 0 || wake_evt)) nd = 0;
      if (m_depth == 2 && (maxd < 2 || act != 0 || wake_evt)) go_wake = 1;
      if (m_depth == 3 && (maxd < 3 || wake_evt || motion_active || tx_active)) go_wake = 1;
      if (!go_wake && nd == m_depth && m_depth < 3 && act == 0 &&
          m_idle + 1 == thr(m_depth) && maxd > m_depth)
        nd = m_depth + 1;
      if (go_wake) begin
        m_wake_left = WAKE_CYC; m_depth = 0; m_idle = 0; entered = 1;
      end else begin
        if (nd != m_depth || act != 0) m_idle = 0;
        else if (m_idle < IDLE_MAX) m_idle = m_idle + 1;
        m_depth = nd;
      end
    end
    e_mode = (m_wake_left > 0) ? 2'd0 : 2'(m_depth);
    e_mc   = (int'(e_mode) != prev);
    e_irq  = entered;
    e_busy = (m_wake_left > 0);
  endtask

  // Inputs are changed by the caller at posedge+1; outputs sampled at posedge+1.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("mode", power_mode, e_mode);
    chk("mode_change", {1'b0, mode_change}, {1'b0, e_mc});
    chk("wake_irq", {1'b0, wake_irq}, {1'b0, e_irq});
    chk("wake_busy", {1'b0, wake_busy}, {1'b0, e_busy});
  endtask

  task automatic flags(input logic [3:0] f);
    {temp_active, hum_active, motion_active, tx_active} = f;
  endtask

  initial begin
    rst = 1'b1;
    flags(4'b0000); wake_evt = 1'b0;
    cfg_max_depth = 2'd3; cfg_force_en = 1'b0; cfg_force_mode = 2'd0;
    model_reset();
    #20;
    chk("rst_mode", power_mode, 2'd0);
    chk("rst_mc", {1'b0, mode_change}, 2'd0);
    chk("rst_irq", {1'b0, wake_irq}, 2'd0);
    chk("rst_busy", {1'b0, wake_busy}, 2'd0);
    rst = 1'b0;

    // idle descent
    repeat (3) step();
    chk("desc_normal", power_mode, 2'd0);
    step();
    chk("desc_low", power_mode, 2'd1);
    chk("desc_low_mc", {1'b0, mode_change}, 2'd1);
    repeat (7) step();
    chk("desc_low_hold", power_mode, 2'd1);
    step();
    chk("desc_sleep", power_mode, 2'd2);
    repeat (15) step();
    chk("desc_sleep_hold", power_mode, 2'd2);
    step();
    chk("desc_deep", power_mode, 2'd3);

    // DEEP ignores temp, wakes on motion
    flags(4'b1000); step();
    chk("deep_temp", power_mode, 2'd3);
    flags(4'b0010); step();
    chk("deep_wake_mode", power_mode, 2'd0);
    chk("deep_wake_irq", {1'b0, wake_irq}, 2'd1);
    chk("deep_wake_busy", {1'b0, wake_busy}, 2'd1);
    flags(4'b0000);
    repeat (2) step();
    chk("wake_busy_3rd", {1'b0, wake_busy}, 2'd1);
    step();
    chk("wake_done_busy", {1'b0, wake_busy}, 2'd0);
    chk("wake_done_mc", {1'b0, mode_change}, 2'd0);

    // activity in LOW
    repeat (4) step();
    chk("act_low", power_mode, 2'd1);
    flags(4'b0100); step();
    chk("act_normal", power_mode, 2'd0);
    chk("act_noirq", {1'b0, wake_irq}, 2'd0);
    flags(4'b0000);
    repeat (3) step();
    chk("act_restart_hold", power_mode, 2'd0);
    step();
    chk("act_restart_low", power_mode, 2'd1);

    // threshold race
    wake_evt = 1'b1; step();
    wake_evt = 1'b0;
    repeat (3) step();
    flags(4'b0001); step();
    chk("race_mode", power_mode, 2'd0);
    flags(4'b0000);
    repeat (3) step();
    chk("race_cleared", power_mode, 2'd0);
    step();
    chk("race_low", power_mode, 2'd1);

    // depth cap
    cfg_max_depth = 2'd1;
    repeat (100) step();
    chk("cap_hold", power_mode, 2'd1);
    cfg_max_depth = 2'd3;
    flags(4'b0100); step();
    flags(4'b0000);
    repeat (28) step();
    chk("cap_deep", power_mode, 2'd3);
    cfg_max_depth = 2'd1; step();
    chk("cap_wake_mode", power_mode, 2'd0);
    chk("cap_wake_irq", {1'b0, wake_irq}, 2'd1);
    repeat (3) step();
    chk("cap_normal_busy", {1'b0, wake_busy}, 2'd0);
    repeat (3) step();
    chk("cap_normal", power_mode, 2'd0);
    step();
    chk("cap_low", power_mode, 2'd1);

    // force and reset mid-WAKE
    cfg_max_depth = 2'd3;
    cfg_force_en = 1'b1; cfg_force_mode = 2'd3; wake_evt = 1'b1; step();
    chk("force_mode", power_mode, 2'd3);
    chk("force_noirq", {1'b0, wake_irq}, 2'd0);
    step();
    chk("force_hold_mc", {1'b0, mode_change}, 2'd0);
    cfg_force_en = 1'b0; step();
    chk("release_irq", {1'b0, wake_irq}, 2'd1);
    wake_evt = 1'b0; step();
    chk("release_busy", {1'b0, wake_busy}, 2'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_wake_mode", power_mode, 2'd0);
    chk("rst_wake_mc", {1'b0, mode_change}, 2'd0);
    chk("rst_wake_irq", {1'b0, wake_irq}, 2'd0);
    chk("rst_wake_busy", {1'b0, wake_busy}, 2'd0);
    model_reset();
    #1 rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      flags({($urandom_range(0, 63) == 0), ($urandom_range(0, 63) == 0),
             ($urandom_range(0, 63) == 0), ($urandom_range(0, 63) == 0)});
      wake_evt = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 199) == 0) cfg_max_depth = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) cfg_force_en = ~cfg_force_en;
      if ($urandom_range(0, 9) == 0) cfg_force_mode = 2'($urandom_range(0, 3));
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
